// File: rtl/uart_txq.sv
// Dual-lane character queue feeding a UART transmitter: write at edge k pops at k+1, line low from k+2.
// No backpressure: characters beyond the free space sampled before the edge are dropped and counted (saturating).
module uart_txq #(
  parameter int CLK_DIV   = 868,
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                   CLK,
  input  logic                   NRST,
  input  logic                   we1,
  input  logic [DATA_BITS-1:0]   wdata1,
  input  logic                   we2,
  input  logic [DATA_BITS-1:0]   wdata2,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic [7:0]             drop_cnt,
  output logic                   uart_tx
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLK_DIV);

  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [LW-1:0]        lvl;
  logic [LW-1:0]        free;

  // write admission
  logic                 has1;
  logic                 has2;
  logic                 acc1;
  logic                 acc2;
  logic                 drop1;
  logic                 drop2;
  logic [1:0]           n_acc;
  logic [DATA_BITS-1:0] head_wdata;
  logic [8:0]           drop_sum;

  // transmitter
  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic [2:0]           bidx;
  logic [2:0]           bidx_nxt;
  logic                 sidx;
  logic                 sidx_nxt;
  logic                 pop;
  logic                 shift;
  logic                 tx_nxt;
  logic                 bit_end;
  logic [DATA_BITS-1:0] shreg;

  // Space is judged on the pre-edge level only, so a pop in the same cycle never frees room for a write.
  always_comb begin
    free       = LW'(DEPTH) - lvl;
    has1       = (free != '0);
    has2       = (free >= LW'(2));
    acc1       = we1 & has1;
    acc2       = we2 & (we1 ? has2 : has1);
    drop1      = we1 & ~acc1;
    drop2      = we2 & ~acc2;
    n_acc      = {1'b0, acc1} + {1'b0, acc2};
    head_wdata = acc1 ? wdata1 : wdata2;
    drop_sum   = {1'b0, drop_cnt} + {8'd0, drop1} + {8'd0, drop2};
  end

  always_ff @(posedge CLK) begin
    if (n_acc != 2'd0) begin
      mem[wptr] <= head_wdata;
    end
    if (acc1 && acc2) begin
      mem[wptr + PW'(1)] <= wdata2;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wptr     <= '0;
      rptr     <= '0;
      lvl      <= '0;
      drop_cnt <= '0;
    end else begin
      wptr     <= wptr + PW'(n_acc);
      rptr     <= rptr + PW'(pop);
      lvl      <= lvl + LW'(n_acc) - LW'(pop);
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // Every bit boundary reloads the counter, so bit timing never accumulates error.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bidx_nxt  = bidx;
    sidx_nxt  = sidx;
    pop       = 1'b0;
    shift     = 1'b0;
    tx_nxt    = 1'b1;
    bit_end   = (cnt == '0);
    unique case (state)
      IDLE: begin
        if (lvl != '0) begin
          pop       = 1'b1;
          state_nxt = START;
          cnt_nxt   = CNT_RELOAD;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          state_nxt = DATA;
          cnt_nxt   = CNT_RELOAD;
          bidx_nxt  = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (bit_end) begin
          cnt_nxt = CNT_RELOAD;
          shift   = 1'b1;
          if (bidx == LAST_BIT) begin
            state_nxt = STOP;
            sidx_nxt  = 1'b0;
          end else begin
            bidx_nxt = bidx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt = CNT_RELOAD;
          if (sidx == LAST_STOP) begin
            // chain straight into the next start bit when more characters wait
            if (lvl != '0) begin
              pop       = 1'b1;
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            sidx_nxt = sidx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state   <= IDLE;
      cnt     <= '0;
      bidx    <= '0;
      sidx    <= 1'b0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bidx    <= bidx_nxt;
      sidx    <= sidx_nxt;
      uart_tx <= tx_nxt;
      if (pop) begin
        shreg <= mem[rptr];
      end else if (shift) begin
        shreg <= shreg >> 1;
      end
    end
  end

  assign level = lvl;
  assign full  = (lvl == LW'(DEPTH));
  assign busy  = (lvl != '0) || (state != IDLE);

endmodule

// File: tb/tb_uart_txq.sv
// Scoreboard bench for uart_txq: stimulus queues expected characters, per-line UART receivers decode and compare.
module tb_uart_txq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic       we1_a, we2_a, full_a, busy_a, tx_a;
  logic [7:0] wd1_a, wd2_a, drop_a;
  logic [2:0] level_a;
  logic       we1_b, we2_b, full_b, busy_b, tx_b;
  logic [6:0] wd1_b, wd2_b;
  logic [7:0] drop_b;
  logic [2:0] level_b;

  uart_txq #(.CLK_DIV(4), .DEPTH(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
    .CLK(clk), .NRST(nrst), .we1(we1_a), .wdata1(wd1_a), .we2(we2_a), .wdata2(wd2_a),
    .full(full_a), .level(level_a), .busy(busy_a), .drop_cnt(drop_a), .uart_tx(tx_a));

  uart_txq #(.CLK_DIV(4), .DEPTH(4), .DATA_BITS(7), .STOP_BITS(2)) u_dut_b (
    .CLK(clk), .NRST(nrst), .we1(we1_b), .wdata1(wd1_b), .we2(we2_b), .wdata2(wd2_b),
    .full(full_b), .level(level_b), .busy(busy_b), .drop_cnt(drop_b), .uart_tx(tx_b));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] ch;
    int         gap;   // required start-to-start distance from previous frame, -1 = any
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input logic e1, input logic [7:0] d1,
                    input logic e2, input logic [7:0] d2);
    if (sel == 0) begin
      we1_a = e1; wd1_a = d1; we2_a = e2; wd2_a = d2;
    end else begin
      we1_b = e1; wd1_b = d1[6:0]; we2_b = e2; wd2_b = d2[6:0];
    end
    step();
    we1_a = 1'b0; we2_a = 1'b0; we1_b = 1'b0; we2_b = 1'b0;
  endtask

  task automatic expect_ch(input int sel, input logic [7:0] ch, input int gap);
    exp_t e;
    e.ch  = ch;
    e.gap = gap;
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy_a || busy_b) && n < limit) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(busy_a || busy_b), 0);
    repeat (4) step();
  endtask

  function automatic logic line(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction

  task automatic wait_neg(input int n, output logic aborted);
    aborted = 1'b0;
    for (int i = 0; i < n && !aborted; i++) begin
      @(negedge clk);
      if (!nrst) aborted = 1'b1;
    end
  endtask

  // Receiver: detect falling edge, sample mid-bit every 4 cycles; frames cut by reset are discarded.
  task automatic rx_loop(input int sel);
    int db, sb, start_cyc, last_start;
    logic prev, ab, ok, start_bit, stop_ok;
    logic [7:0] ch;
    exp_t e;
    string tag;
    db = (sel == 0) ? 8 : 7;
    sb = (sel == 0) ? 1 : 2;
    tag = (sel == 0) ? "a" : "b";
    prev = 1'b1;
    last_start = -100000;
    forever begin
      @(negedge clk);
      if (!nrst || !(prev && !line(sel))) begin
        prev = nrst ? line(sel) : 1'b1;
        continue;
      end
      start_cyc = cyc;
      ch = '0;
      stop_ok = 1'b1;
      wait_neg(2, ab);
      ok = !ab;
      start_bit = line(sel);
      for (int i = 0; i < db; i++) begin
        if (ok) begin
          wait_neg(4, ab);
          ok = !ab;
          ch[i] = line(sel);
        end
      end
      for (int s = 0; s < sb; s++) begin
        if (ok) begin
          wait_neg(4, ab);
          ok = !ab;
          stop_ok = stop_ok & line(sel);
        end
      end
      prev = 1'b1;
      if (!ok) continue;
      if ((sel == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL rx_%s_unexpected: got frame 0x%0h, want no frame", tag, ch);
      end else begin
        e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
        check({"rx_start_", tag}, 32'(start_bit), 0);
        check({"rx_char_", tag}, 32'(ch), 32'(e.ch));
        check({"rx_stop_", tag}, 32'(stop_ok), 1);
        if (e.gap >= 0) check({"rx_gap_", tag}, start_cyc - last_start, e.gap);
      end
      last_start = start_cyc;
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);

  initial begin
    repeat (20000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int   prev_drop;
    logic wrapped;
    nrst = 1'b1;
    we1_a = 1'b0; we2_a = 1'b0; wd1_a = '0; wd2_a = '0;
    we1_b = 1'b0; we2_b = 1'b0; wd1_b = '0; wd2_b = '0;
    #2 nrst = 1'b0;
    repeat (3) step();

    check("rst_tx_a", 32'(tx_a), 1);
    check("rst_level_a", 32'(level_a), 0);
    check("rst_full_a", 32'(full_a), 0);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_drop_a", 32'(drop_a), 0);
    check("rst_tx_b", 32'(tx_b), 1);

    // write held through reset is ignored, then taken at the first edge with reset released
    we1_a = 1'b1; wd1_a = 8'h55;
    step();
    check("rst_write_ignored", 32'(level_a), 0);
    nrst = 1'b1;
    step();
    we1_a = 1'b0;
    expect_ch(0, 8'h55, -1);
    check("wr_level", 32'(level_a), 1);
    check("wr_busy", 32'(busy_a), 1);
    step();
    check("pop_level", 32'(level_a), 0);
    check("lat_tx_k1", 32'(tx_a), 1);
    step();
    check("lat_tx_k2", 32'(tx_a), 0);
    repeat (38) step();
    check("busy_k40", 32'(busy_a), 1);
    step();
    check("busy_k41", 32'(busy_a), 0);
    wait_idle(100);

    // dual write, back-to-back frames
    wr(0, 1'b1, 8'h41, 1'b1, 8'h42);
    expect_ch(0, 8'h41, -1);
    expect_ch(0, 8'h42, 40);
    check("dual_level", 32'(level_a), 2);
    wait_idle(200);

    // fill to 3 behind a busy shifter, then partial and total drops
    wr(0, 1'b1, 8'h10, 1'b0, 8'h00);
    wr(0, 1'b1, 8'h11, 1'b1, 8'h12);
    wr(0, 1'b1, 8'h13, 1'b0, 8'h00);
    check("fill3_level", 32'(level_a), 3);
    check("fill3_full", 32'(full_a), 0);
    wr(0, 1'b1, 8'hA0, 1'b1, 8'hA1);
    check("space1_level", 32'(level_a), 4);
    check("space1_full", 32'(full_a), 1);
    check("space1_drop", 32'(drop_a), 1);
    wr(0, 1'b1, 8'hB0, 1'b1, 8'hB1);
    check("space0_drop", 32'(drop_a), 3);
    check("space0_level", 32'(level_a), 4);
    expect_ch(0, 8'h10, -1);
    expect_ch(0, 8'h11, 40);
    expect_ch(0, 8'h12, 40);
    expect_ch(0, 8'h13, 40);
    expect_ch(0, 8'hA0, 40);
    wait_idle(300);

    // saturation: 300 single writes against a full queue; each drain slot refills with 0xC3
    wr(0, 1'b1, 8'h20, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) wr(0, 1'b1, 8'(8'h20 + i), 1'b0, 8'h00);
    check("sat_fill_level", 32'(level_a), 4);
    check("sat_fill_full", 32'(full_a), 1);
    expect_ch(0, 8'h20, -1);
    for (int i = 1; i <= 4; i++) expect_ch(0, 8'(8'h20 + i), 40);
    for (int i = 0; i < 7; i++) expect_ch(0, 8'hC3, 40);
    prev_drop = int'(drop_a);
    wrapped = 1'b0;
    we1_a = 1'b1; wd1_a = 8'hC3;
    for (int i = 0; i < 300; i++) begin
      step();
      if (int'(drop_a) < prev_drop) wrapped = 1'b1;
      prev_drop = int'(drop_a);
    end
    we1_a = 1'b0;
    check("sat_drop", 32'(drop_a), 255);
    check("sat_no_wrap", 32'(wrapped), 0);
    wait_idle(600);

    // asynchronous reset during data bit 3 of 0x00 with 0x5A waiting
    wr(0, 1'b1, 8'h00, 1'b1, 8'h5A);
    repeat (19) step();
    check("pre_rst_line", 32'(tx_a), 0);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx_a), 1);
    check("mid_rst_level", 32'(level_a), 0);
    check("mid_rst_full", 32'(full_a), 0);
    check("mid_rst_busy", 32'(busy_a), 0);
    check("mid_rst_drop", 32'(drop_a), 0);
    step();
    nrst = 1'b1;
    wr(0, 1'b1, 8'h3C, 1'b0, 8'h00);
    expect_ch(0, 8'h3C, -1);
    step();
    check("retx_tx_k1", 32'(tx_a), 1);
    step();
    check("retx_tx_k2", 32'(tx_a), 0);
    wait_idle(100);
    check("retx_drop", 32'(drop_a), 0);

    // 7 data bits, 2 stop bits: 40-cycle frame
    wr(1, 1'b1, 8'h7F, 1'b0, 8'h00);
    expect_ch(1, 8'h7F, -1);
    step();
    check("b_tx_k1", 32'(tx_b), 1);
    step();
    check("b_tx_k2", 32'(tx_b), 0);
    repeat (38) step();
    check("b_busy_k40", 32'(busy_b), 1);
    step();
    check("b_busy_k41", 32'(busy_b), 0);
    wait_idle(100);
    wr(1, 1'b1, 8'h01, 1'b1, 8'h40);
    expect_ch(1, 8'h01, -1);
    expect_ch(1, 8'h40, 40);
    check("b_dual_level", 32'(level_b), 2);
    wait_idle(200);

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    check("b_full", 32'(full_b), 0);
    check("b_drop", 32'(drop_b), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_txq.md
UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 Parameter CLK_DIV, default 868: clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DEPTH, default 16: FIFO entries; power of two, 4..256.
REQ-003 Parameter DATA_BITS, default 8: bits per character; legal range 5..8.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; 1 or 2.
REQ-005 CLK  input  1  system clock; all state updates on rising edge.
REQ-006 NRST  input  1  reset, asynchronous, active-low; one clock, no other clock domains.
REQ-007 we1  input  1  store-lane-1 write strobe (older instruction of issue pair).
REQ-008 wdata1  input  DATA_BITS  lane-1 character.
REQ-009 we2  input  1  store-lane-2 write strobe (younger instruction).
REQ-010 wdata2  input  DATA_BITS  lane-2 character.
REQ-011 full  output  1  high when level == DEPTH.
REQ-012 level  output  clog2(DEPTH)+1  characters queued, excluding the one in the shifter.
REQ-013 busy  output  1  high when level != 0 or transmitter not in IDLE.
REQ-014 drop_cnt  output  8  count of rejected characters, saturating at 255.
REQ-015 uart_tx  output  1  serial line, registered, idle high.

Function
REQ-016 Free space for a cycle SHALL be DEPTH - level sampled before the edge; a same-cycle pop SHALL NOT create space for that cycle's writes.
REQ-017 Single write with space >= 1: character enqueued at the edge; level +1 (net of any pop).
REQ-018 we1 and we2 together with space >= 2: wdata1 enqueued ahead of wdata2; level +2 (net of any pop).
REQ-019 we1 and we2 together with space == 1: wdata1 accepted, wdata2 dropped, drop_cnt +1.
REQ-020 Any write with space == 0: every asserted lane dropped; drop_cnt increases by number of dropped lanes (1 or 2), saturating at 255.
REQ-021 Transmitter FSM states: IDLE, START, DATA, STOP.
REQ-022 IDLE: uart_tx = 1; if level != 0 at an edge, pop head into shifter, go to START.
REQ-023 START: uart_tx = 0 for exactly CLK_DIV cycles, then DATA.
REQ-024 DATA: DATA_BITS bits, LSB first, each exactly CLK_DIV cycles, then STOP.
REQ-025 STOP: uart_tx = 1 for STOP_BITS*CLK_DIV cycles; on final cycle, if level != 0 pop and go to START (no idle gap), else go to IDLE.
REQ-026 Latency: write accepted at edge k into empty FIFO with FSM in IDLE; pop at edge k+1; uart_tx low from edge k+2.
REQ-027 Bit timing counter SHALL be clog2(CLK_DIV) bits wide and reload on every bit boundary; no cumulative drift.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.
REQ-029 Writes during an active frame SHALL NOT disturb the character in the shifter.

Reset
REQ-030 NRST low SHALL immediately force uart_tx = 1, FSM = IDLE, level = 0, full = 0, busy = 0, drop_cnt = 0, pointers = 0, including mid-frame.
REQ-031 Writes while NRST low SHALL be ignored; the first write is accepted at the first edge with NRST high.

Verification (CLK_DIV=4, DEPTH=4, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-032 Single we1, wdata1=0x55 -> uart_tx low from 2nd edge after write; line 0,1,0,1,0,1,0,1,0,1 at 4-cycle bits; busy falls after 40 bit-cycles plus pop.
REQ-033 we1=0x41 and we2=0x42 same cycle -> level=2; frames 0x41 then 0x42 back-to-back, stop bit directly followed by start bit.
REQ-034 Fill to level=3, then we1=0xA0 and we2=0xA1 same cycle while shifter busy -> 0xA0 queued, full=1, drop_cnt=1; a further dual write -> drop_cnt=3.
REQ-035 Drive 300 single writes into full FIFO with DEPTH=4 -> drop_cnt saturates at 255, never wraps.
REQ-036 Assert NRST low during DATA bit 3 -> uart_tx=1 same cycle without waiting for an edge; all status outputs zero; next write retransmits cleanly.
REQ-037 STOP_BITS=2, DATA_BITS=7, write 0x7F -> frame = 1 start, 7 ones, 2 stop bits = 40 cycles of stop-inclusive frame; no eighth data bit.
